// File: rtl/motoro301_uart_cmd_rx.sv
// motoro301 UART 8N1 command receiver.
// Recovers bytes from uRx, parses A5 CMD FH FL CS frames, drives motor top.
module motoro301_uart_cmd_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int DEF_FREQ     = 100,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clk50mhz,
  input  logic       reset,
  input  logic       uRx,
  output logic       m3start,
  output logic       m3invOrStop,
  output logic [9:0] m3freq,
  output logic       cmdStrobe,
  output logic       rxErr,
  output logic       byteValid,
  output logic [7:0] byteData
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TO  = TIMEOUT_BITS * DIV;
  localparam int CW  = $clog2(TO + 1);

  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] TOV  = CW'(TO);
  localparam logic [9:0]    DEFF = 10'(DEF_FREQ);

  typedef enum logic [2:0] {
    B_IDLE, B_START, B_DATA, B_STOP, B_BREAK
  } bst_e;

  typedef enum logic [2:0] {
    P_HDR, P_CMD, P_FH, P_FL, P_CS
  } pst_e;

  logic s1_q, s2_q, rx;

  bst_e          bst_q, bst_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sh_q, sh_d;
  logic          bv_q, bv_d;
  logic [7:0]    bdat_q, bdat_d;
  logic          ferr_q, ferr_d;

  pst_e          pst_q, pst_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [1:0]    fh_q, fh_d;
  logic [7:0]    fl_q, fl_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          start_q, start_d;
  logic          inv_q, inv_d;
  logic [9:0]    freq_q, freq_d;
  logic          stb_q, stb_d;
  logic          perr_q, perr_d;

  // two-flop synchronizer on the async line, idles high
  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= uRx;
      s2_q <= s1_q;
    end
  end

  assign rx = s2_q;

  // bit-level receiver state
  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      bst_q  <= B_IDLE;
      bcnt_q <= '0;
      bidx_q <= '0;
      sh_q   <= '0;
      bv_q   <= 1'b0;
      bdat_q <= '0;
      ferr_q <= 1'b0;
    end else begin
      bst_q  <= bst_d;
      bcnt_q <= bcnt_d;
      bidx_q <= bidx_d;
      sh_q   <= sh_d;
      bv_q   <= bv_d;
      bdat_q <= bdat_d;
      ferr_q <= ferr_d;
    end
  end

  // bit FSM: mid-bit sampling, LSB first, stop=0 is a framing error
  always_comb begin
    bst_d  = bst_q;
    bcnt_d = bcnt_q;
    bidx_d = bidx_q;
    sh_d   = sh_q;
    bv_d   = 1'b0;
    bdat_d = bdat_q;
    ferr_d = 1'b0;
    case (bst_q)
      B_IDLE: begin
        if (!rx) begin
          bst_d  = B_START;
          bcnt_d = HALF;
        end
      end
      B_START: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - 1'b1;
        end else if (!rx) begin
          bst_d  = B_DATA;
          bcnt_d = FULL;
          bidx_d = '0;
        end else begin
          bst_d = B_IDLE;
        end
      end
      B_DATA: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - 1'b1;
        end else begin
          sh_d   = {rx, sh_q[7:1]};
          bcnt_d = FULL;
          if (bidx_q == 3'd7) bst_d = B_STOP;
          else bidx_d = bidx_q + 1'b1;
        end
      end
      B_STOP: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - 1'b1;
        end else if (rx) begin
          bv_d   = 1'b1;
          bdat_d = sh_q;
          bst_d  = B_IDLE;
        end else begin
          ferr_d = 1'b1;
          bst_d  = B_BREAK;
        end
      end
      B_BREAK: begin
        if (rx) bst_d = B_IDLE;
      end
      default: bst_d = B_IDLE;
    endcase
  end

  // frame parser and motor command state
  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      pst_q   <= P_HDR;
      cmd_q   <= '0;
      fh_q    <= '0;
      fl_q    <= '0;
      tcnt_q  <= '0;
      start_q <= 1'b0;
      inv_q   <= 1'b0;
      freq_q  <= DEFF;
      stb_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      pst_q   <= pst_d;
      cmd_q   <= cmd_d;
      fh_q    <= fh_d;
      fl_q    <= fl_d;
      tcnt_q  <= tcnt_d;
      start_q <= start_d;
      inv_q   <= inv_d;
      freq_q  <= freq_d;
      stb_q   <= stb_d;
      perr_q  <= perr_d;
    end
  end

  // parser FSM: validate each field, commit on good checksum
  always_comb begin
    pst_d   = pst_q;
    cmd_d   = cmd_q;
    fh_d    = fh_q;
    fl_d    = fl_q;
    tcnt_d  = tcnt_q;
    start_d = start_q;
    inv_d   = inv_q;
    freq_d  = freq_q;
    stb_d   = 1'b0;
    perr_d  = 1'b0;
    if (bv_q) tcnt_d = '0;
    else if (tcnt_q != TOV) tcnt_d = tcnt_q + 1'b1;
    if (bv_q) begin
      case (pst_q)
        P_HDR: begin
          if (bdat_q == 8'hA5) pst_d = P_CMD;
        end
        P_CMD: begin
          if (bdat_q[7:2] != 6'd0) begin
            perr_d = 1'b1;
            pst_d  = P_HDR;
          end else begin
            cmd_d = bdat_q[1:0];
            pst_d = P_FH;
          end
        end
        P_FH: begin
          if (bdat_q[7:2] != 6'd0) begin
            perr_d = 1'b1;
            pst_d  = P_HDR;
          end else begin
            fh_d  = bdat_q[1:0];
            pst_d = P_FL;
          end
        end
        P_FL: begin
          fl_d  = bdat_q;
          pst_d = P_CS;
        end
        P_CS: begin
          pst_d = P_HDR;
          if (bdat_q == ({6'd0, cmd_q ^ fh_q} ^ fl_q)) begin
            start_d = cmd_q[0];
            inv_d   = cmd_q[1];
            freq_d  = {fh_q, fl_q};
            stb_d   = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: pst_d = P_HDR;
      endcase
    end else if (pst_q != P_HDR && (ferr_q || tcnt_q == TOV)) begin
      pst_d = P_HDR;
    end
  end

  assign m3start     = start_q;
  assign m3invOrStop = inv_q;
  assign m3freq      = freq_q;
  assign cmdStrobe   = stb_q;
  assign rxErr       = ferr_q | perr_q;
  assign byteValid   = bv_q;
  assign byteData    = bdat_q;

endmodule

// File: tb/tb_motoro301_uart_cmd_rx.sv
// Directed bench for motoro301_uart_cmd_rx at DIV=8.
// Pulse monitor on negedge, checks after settled waits.
module tb_motoro301_uart_cmd_rx;

  localparam int DIV = 8;

  logic       clk50mhz;
  logic       reset;
  logic       uRx;
  logic       m3start;
  logic       m3invOrStop;
  logic [9:0] m3freq;
  logic       cmdStrobe;
  logic       rxErr;
  logic       byteValid;
  logic [7:0] byteData;

  int n_chk, n_err;
  int n_bv, n_stb, n_rxe, n_algn, n_both;
  logic prev_bv;

  motoro301_uart_cmd_rx #(
    .CLK_HZ(80), .BAUD(10), .DEF_FREQ(100), .TIMEOUT_BITS(40)
  ) dut (
    .clk50mhz(clk50mhz),
    .reset(reset),
    .uRx(uRx),
    .m3start(m3start),
    .m3invOrStop(m3invOrStop),
    .m3freq(m3freq),
    .cmdStrobe(cmdStrobe),
    .rxErr(rxErr),
    .byteValid(byteValid),
    .byteData(byteData)
  );

  initial clk50mhz = 1'b0;
  always #5 clk50mhz = ~clk50mhz;

  always @(negedge clk50mhz) begin
    if (byteValid) n_bv++;
    if (cmdStrobe) n_stb++;
    if (rxErr) n_rxe++;
    if (cmdStrobe && prev_bv) n_algn++;
    if (cmdStrobe && rxErr) n_both++;
    prev_bv = byteValid;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50mhz);
    #1;
  endtask

  task automatic clr();
    n_bv = 0;
    n_stb = 0;
    n_rxe = 0;
    n_algn = 0;
    n_both = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uRx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uRx = b[i];
      tick(DIV);
    end
    uRx = stop;
    tick(DIV);
    uRx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] s);
    send_byte(8'hA5, 1'b1);
    send_byte(c, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
    send_byte(s, 1'b1);
    tick(12);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    prev_bv = 1'b0;
    clr();
    uRx = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    chk("rst_start", 32'(m3start), 0);
    chk("rst_inv", 32'(m3invOrStop), 0);
    chk("rst_freq", 32'(m3freq), 100);
    chk("rst_stb", 32'(cmdStrobe), 0);
    chk("rst_err", 32'(rxErr), 0);
    chk("rst_bv", 32'(byteValid), 0);
    chk("rst_bdata", 32'(byteData), 0);

    clr();
    send_frame(8'h01, 8'h00, 8'hC8, 8'hC9);
    chk("t2_nbv", 32'(n_bv), 5);
    chk("t2_bdata", 32'(byteData), 32'hC9);
    chk("t2_start", 32'(m3start), 1);
    chk("t2_inv", 32'(m3invOrStop), 0);
    chk("t2_freq", 32'(m3freq), 200);
    chk("t2_nstb", 32'(n_stb), 1);
    chk("t2_align", 32'(n_algn), 1);
    chk("t2_nerr", 32'(n_rxe), 0);

    clr();
    send_frame(8'h03, 8'h01, 8'h2C, 8'h00);
    chk("t3_nerr", 32'(n_rxe), 1);
    chk("t3_nstb", 32'(n_stb), 0);
    chk("t3_start", 32'(m3start), 1);
    chk("t3_inv", 32'(m3invOrStop), 0);
    chk("t3_freq", 32'(m3freq), 200);

    clr();
    uRx = 1'b0;
    tick(3);
    uRx = 1'b1;
    tick(40);
    chk("t4_nbv", 32'(n_bv), 0);
    chk("t4_nerr", 32'(n_rxe), 0);

    clr();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h55, 1'b0);
    tick(20);
    chk("t5_ferr", 32'(n_rxe), 1);
    chk("t5_nbv", 32'(n_bv), 1);
    clr();
    send_frame(8'h02, 8'h01, 8'h2C, 8'h2F);
    chk("t5_nstb", 32'(n_stb), 1);
    chk("t5_nerr", 32'(n_rxe), 0);
    chk("t5_start", 32'(m3start), 0);
    chk("t5_inv", 32'(m3invOrStop), 1);
    chk("t5_freq", 32'(m3freq), 300);

    clr();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    tick(400);
    send_frame(8'h01, 8'h00, 8'h64, 8'h65);
    chk("t6_nstb", 32'(n_stb), 1);
    chk("t6_nerr", 32'(n_rxe), 0);
    chk("t6_start", 32'(m3start), 1);
    chk("t6_inv", 32'(m3invOrStop), 0);
    chk("t6_freq", 32'(m3freq), 100);

    send_byte(8'hA5, 1'b1);
    uRx = 1'b0;
    tick(DIV);
    uRx = 1'b1;
    tick(2 * DIV);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("t6_rst_start", 32'(m3start), 0);
    chk("t6_rst_inv", 32'(m3invOrStop), 0);
    chk("t6_rst_freq", 32'(m3freq), 100);
    clr();
    tick(100);
    chk("t6_rst_nbv", 32'(n_bv), 0);
    chk("never_both", 32'(n_both), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
